// File: rtl/afe_pkg.sv
// Shared definitions for the AFE command path: opcode and run-state encodings
// plus the bit-field layout of a command word.
package afe_pkg;

  typedef enum logic [1:0] {
    OP_NOOP  = 2'b00,
    OP_START = 2'b01,
    OP_STOP  = 2'b10,
    OP_RSVD  = 2'b11
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARM      = 2'd1,
    ST_RUNNING  = 2'd2,
    ST_STOPPING = 2'd3
  } run_state_t;

  localparam int OPCODE_MSB  = 15;
  localparam int OPCODE_LSB  = 14;
  localparam int VALUE_MSB   = 13;
  localparam int VALUE_LSB   = 0;
  localparam int VALUE_WIDTH = VALUE_MSB - VALUE_LSB + 1;

endpackage

// File: rtl/run_controller.sv
// Acquisition run-state controller: validates commands against the run state,
// arms the AFE for a fixed window, and defers stops to the next frame boundary.
module run_controller
  import afe_pkg::*;
#(
  parameter int CMD_WIDTH     = 16,
  parameter int COUNT_WIDTH   = 32,
  parameter int VAL_SHIFT     = 2,
  parameter int MIN_COUNT     = 64,
  parameter int DEFAULT_COUNT = 5000,
  parameter int ARM_CYCLES    = 16
) (
  input  logic                   clk_in,
  input  logic                   reset_n,
  input  logic [CMD_WIDTH-1:0]   cmd_word,
  input  logic                   cmd_valid,
  input  logic                   frame_done,
  output logic                   running,
  output logic                   afe_reset,
  output logic [COUNT_WIDTH-1:0] integration_clock_count,
  output logic                   cmd_ack,
  output logic                   cmd_nack,
  output logic                   cmd_error,
  output logic [1:0]             state_out
);

  localparam int ARM_W = $clog2(ARM_CYCLES + 1);

  run_state_t             state, state_nxt;
  logic [ARM_W-1:0]       arm_cnt, arm_nxt;
  logic [COUNT_WIDTH-1:0] count_nxt, scaled;
  logic                   ack_nxt, nack_nxt, error_nxt;
  opcode_t                opcode;
  logic [VALUE_WIDTH-1:0] value;

  // Command handshake: cmd_valid is a one-cycle strobe with no back-pressure;
  // every strobed word is answered by exactly one of cmd_ack / cmd_nack on the
  // following cycle.
  assign opcode = opcode_t'(cmd_word[OPCODE_MSB:OPCODE_LSB]);
  assign value  = cmd_word[VALUE_MSB:VALUE_LSB];
  assign scaled = COUNT_WIDTH'(value) << VAL_SHIFT;

  always_comb begin
    state_nxt = state;
    arm_nxt   = arm_cnt;
    count_nxt = integration_clock_count;
    ack_nxt   = 1'b0;
    nack_nxt  = 1'b0;
    error_nxt = cmd_error;

    case (state)
      ST_ARM: begin
        if (arm_cnt <= ARM_W'(1)) state_nxt = ST_RUNNING;
        else                      arm_nxt   = arm_cnt - ARM_W'(1);
      end
      ST_STOPPING: if (frame_done) state_nxt = ST_IDLE;
      default: ;
    endcase

    // Commands override the autonomous transitions above.
    if (cmd_valid) begin
      case (opcode)
        OP_NOOP: ack_nxt = 1'b1;
        OP_START: begin
          if (state == ST_IDLE) begin
            ack_nxt   = 1'b1;
            count_nxt = (scaled < COUNT_WIDTH'(MIN_COUNT)) ? COUNT_WIDTH'(MIN_COUNT) : scaled;
            arm_nxt   = ARM_W'(ARM_CYCLES);
            state_nxt = ST_ARM;
          end else begin
            nack_nxt  = 1'b1;
            error_nxt = 1'b1;
          end
        end
        OP_STOP: begin
          ack_nxt = 1'b1;
          case (state)
            ST_ARM:     state_nxt = ST_IDLE;
            ST_RUNNING: state_nxt = frame_done ? ST_IDLE : ST_STOPPING;
            default: ;
          endcase
        end
        default: begin
          nack_nxt  = 1'b1;
          error_nxt = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state                   <= ST_IDLE;
      arm_cnt                 <= '0;
      integration_clock_count <= COUNT_WIDTH'(DEFAULT_COUNT);
      cmd_ack                 <= 1'b0;
      cmd_nack                <= 1'b0;
      cmd_error               <= 1'b0;
      running                 <= 1'b0;
      afe_reset               <= 1'b0;
    end else begin
      state                   <= state_nxt;
      arm_cnt                 <= arm_nxt;
      integration_clock_count <= count_nxt;
      cmd_ack                 <= ack_nxt;
      cmd_nack                <= nack_nxt;
      cmd_error               <= error_nxt;
      // Level outputs follow the next state so they align with state_out.
      running                 <= (state_nxt == ST_RUNNING) || (state_nxt == ST_STOPPING);
      afe_reset               <= (state_nxt == ST_ARM);
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: a cycle-deadline reference model checked
// every cycle, plus hand-computed expectations at key points.
module tb_run_controller;

  localparam int ARM_CYCLES = 16;

  logic        clk_in = 1'b0;
  logic        reset_n;
  logic [15:0] cmd_word;
  logic        cmd_valid;
  logic        frame_done;
  logic        running, afe_reset, cmd_ack, cmd_nack, cmd_error;
  logic [31:0] integration_clock_count;
  logic [1:0]  state_out;

  int n_checks = 0;
  int n_errors = 0;

  run_controller dut (
    .clk_in                  (clk_in),
    .reset_n                 (reset_n),
    .cmd_word                (cmd_word),
    .cmd_valid               (cmd_valid),
    .frame_done              (frame_done),
    .running                 (running),
    .afe_reset               (afe_reset),
    .integration_clock_count (integration_clock_count),
    .cmd_ack                 (cmd_ack),
    .cmd_nack                (cmd_nack),
    .cmd_error               (cmd_error),
    .state_out               (state_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the arming window is tracked as an absolute edge deadline.
  int          cyc;
  int          m_state;
  int          m_run_at;
  logic [31:0] m_count;
  logic        m_ack, m_nack, m_error;
  logic [1:0]  m_op;
  assign m_op = cmd_word[15:14];

  function automatic logic [31:0] clamp_count(input logic [13:0] v);
    int scaled;
    scaled = int'(v) * 4;
    return (scaled < 64) ? 32'd64 : 32'(scaled);
  endfunction

  always @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      cyc      <= 0;
      m_state  <= 0;
      m_run_at <= 0;
      m_count  <= 32'd5000;
      m_ack    <= 1'b0;
      m_nack   <= 1'b0;
      m_error  <= 1'b0;
    end else begin
      cyc    <= cyc + 1;
      m_ack  <= 1'b0;
      m_nack <= 1'b0;
      if (cmd_valid && m_op == 2'b01 && m_state == 0) begin
        m_ack    <= 1'b1;
        m_count  <= clamp_count(cmd_word[13:0]);
        m_state  <= 1;
        m_run_at <= cyc + ARM_CYCLES;
      end else if (cmd_valid && m_op == 2'b10 && (m_state == 1 || (m_state == 2 && frame_done))) begin
        m_ack   <= 1'b1;
        m_state <= 0;
      end else if (cmd_valid && m_op == 2'b10 && m_state == 2) begin
        m_ack   <= 1'b1;
        m_state <= 3;
      end else begin
        if (cmd_valid) begin
          if (m_op == 2'b00 || m_op == 2'b10) m_ack <= 1'b1;
          else begin
            m_nack  <= 1'b1;
            m_error <= 1'b1;
          end
        end
        if (m_state == 1 && cyc == m_run_at) m_state <= 2;
        if (m_state == 3 && frame_done)      m_state <= 0;
      end
    end
  end

  always @(negedge clk_in) begin
    if (reset_n) begin
      check("model_state",     32'(state_out), 32'(m_state));
      check("model_running",   32'(running), 32'(m_state == 2 || m_state == 3));
      check("model_afe_reset", 32'(afe_reset), 32'(m_state == 1));
      check("model_count",     integration_clock_count, m_count);
      check("model_ack",       32'(cmd_ack), 32'(m_ack));
      check("model_nack",      32'(cmd_nack), 32'(m_nack));
      check("model_error",     32'(cmd_error), 32'(m_error));
    end
  end

  // Presents one command for one cycle; returns in the cycle its response is visible.
  task automatic send_cmd(input logic [1:0] op, input logic [13:0] val, input logic with_frame);
    @(negedge clk_in);
    cmd_word   = {op, val};
    cmd_valid  = 1'b1;
    frame_done = with_frame;
    @(negedge clk_in);
    cmd_valid  = 1'b0;
    frame_done = 1'b0;
    cmd_word   = 16'($urandom_range(0, 65535));
  endtask

  task automatic pulse_frame();
    @(negedge clk_in);
    frame_done = 1'b1;
    @(negedge clk_in);
    frame_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  initial begin
    reset_n    = 1'b0;
    cmd_word   = '0;
    cmd_valid  = 1'b0;
    frame_done = 1'b0;
    idle(3);
    reset_n = 1'b1;
    check("reset_state", 32'(state_out), 32'd0);
    check("reset_count", integration_clock_count, 32'd5000);
    check("reset_flags", {29'd0, cmd_ack, cmd_nack, cmd_error}, 32'd0);

    // START val=100: count 400, arm window, then running
    send_cmd(2'b01, 14'd100, 1'b0);
    check("start_ack", 32'(cmd_ack), 32'd1);
    check("start_count", integration_clock_count, 32'd400);
    check("start_afe", 32'(afe_reset), 32'd1);
    idle(15);
    check("arm_last_afe", 32'(afe_reset), 32'd1);
    check("arm_last_run", 32'(running), 32'd0);
    idle(1);
    check("run_rise", 32'(running), 32'd1);
    check("run_afe_low", 32'(afe_reset), 32'd0);
    check("run_state", 32'(state_out), 32'd2);

    // frame_done in RUNNING without STOP is ignored
    pulse_frame();
    check("frame_ignored", 32'(state_out), 32'd2);

    // STOP in RUNNING, frame 30 cycles later
    send_cmd(2'b10, 14'd0, 1'b0);
    check("stop_ack", 32'(cmd_ack), 32'd1);
    check("stopping_state", 32'(state_out), 32'd3);
    check("stopping_run", 32'(running), 32'd1);
    idle(28);
    check("stopping_hold", 32'(running), 32'd1);
    pulse_frame();
    check("stop_done_state", 32'(state_out), 32'd0);
    check("stop_done_run", 32'(running), 32'd0);

    // frame_done in IDLE ignored; STOP in IDLE acked
    pulse_frame();
    check("idle_frame", 32'(state_out), 32'd0);
    send_cmd(2'b10, 14'd7, 1'b0);
    check("idle_stop_ack", 32'(cmd_ack), 32'd1);

    // Reserved opcode, then NOOP
    check("err_before", 32'(cmd_error), 32'd0);
    send_cmd(2'b11, 14'd3, 1'b0);
    check("rsvd_nack", 32'(cmd_nack), 32'd1);
    check("rsvd_error", 32'(cmd_error), 32'd1);
    send_cmd(2'b00, 14'd0, 1'b0);
    check("noop_ack", 32'(cmd_ack), 32'd1);
    check("noop_nack", 32'(cmd_nack), 32'd0);
    check("error_sticky", 32'(cmd_error), 32'd1);

    // START val=5 clamps; second START while RUNNING rejected
    send_cmd(2'b01, 14'd5, 1'b0);
    check("clamp_count", integration_clock_count, 32'd64);
    idle(ARM_CYCLES);
    check("clamp_running", 32'(running), 32'd1);
    send_cmd(2'b01, 14'd9, 1'b0);
    check("restart_nack", 32'(cmd_nack), 32'd1);
    check("restart_count", integration_clock_count, 32'd64);
    check("restart_state", 32'(state_out), 32'd2);

    // STOP coincident with frame_done in RUNNING
    send_cmd(2'b10, 14'd0, 1'b1);
    check("stop_frame_state", 32'(state_out), 32'd0);
    check("stop_frame_run", 32'(running), 32'd0);

    // STOP during arm cycle 5
    send_cmd(2'b01, 14'd20, 1'b0);
    check("abort_count", integration_clock_count, 32'd80);
    idle(3);
    send_cmd(2'b10, 14'd0, 1'b0);
    check("abort_state", 32'(state_out), 32'd0);
    check("abort_afe", 32'(afe_reset), 32'd0);
    for (int i = 0; i < 20; i++) begin
      check("abort_no_run", 32'(running), 32'd0);
      idle(1);
    end

    // Asynchronous reset mid-run
    send_cmd(2'b01, 14'd50, 1'b0);
    idle(ARM_CYCLES);
    check("pre_reset_run", 32'(running), 32'd1);
    @(negedge clk_in);
    #3 reset_n = 1'b0;
    #1;
    check("areset_state", 32'(state_out), 32'd0);
    check("areset_run", 32'(running), 32'd0);
    check("areset_afe", 32'(afe_reset), 32'd0);
    check("areset_count", integration_clock_count, 32'd5000);
    check("areset_flags", {29'd0, cmd_ack, cmd_nack, cmd_error}, 32'd0);
    @(negedge clk_in);
    reset_n = 1'b1;
    send_cmd(2'b01, 14'd0, 1'b0);
    check("zero_val_count", integration_clock_count, 32'd64);
    check("zero_val_state", 32'(state_out), 32'd1);
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/run_controller.md
# run_controller

Acquisition run-state controller between the USB command path and the readout controller. Accepts 16-bit command words (2-bit opcode, 14-bit value), validates them against the current run state, and drives the `running` level and `integration_clock_count` consumed by the readout controller. A fixed AFE-reset arming window precedes every run. Stops are deferred to the next frame boundary so no frame is ever truncated.

## Interface
- `CMD_WIDTH`, 16, command word width; opcode is `[15:14]`, value is `[13:0]`
- `COUNT_WIDTH`, 32, width of `integration_clock_count`
- `VAL_SHIFT`, 2, left shift applied to the command value to form the count
- `MIN_COUNT`, 64, floor applied to the integration count
- `DEFAULT_COUNT`, 5000, reset value of `integration_clock_count`
- `ARM_CYCLES`, 16, number of cycles `afe_reset` is held before `running` asserts (must be ≥ 1)

Ports:
- `clk_in` input 1: single system clock. Everything in the block is on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `cmd_word` input CMD_WIDTH: command word, qualified by `cmd_valid`.
- `cmd_valid` input 1: one-cycle strobe marking a new command.
- `frame_done` input 1: one-cycle pulse from the readout controller at the end of each frame.
- `running` output 1: level; the readout controller acquires while this is high.
- `afe_reset` output 1: high only during the ARM state.
- `integration_clock_count` output COUNT_WIDTH: integration length, in clocks.
- `cmd_ack` output 1: one-cycle pulse, command accepted.
- `cmd_nack` output 1: one-cycle pulse, command rejected.
- `cmd_error` output 1: sticky flag, set by any rejected command; cleared only by reset.
- `state_out` output 2: current state encoding, for debug.

## Operation
- **States:** IDLE=0, ARM=1, RUNNING=2, STOPPING=3.
- **Opcodes:** NOOP=00, START=01, STOP=10; 11 is reserved.
- `cmd_valid` is decoded on every cycle; exactly one of `cmd_ack` or `cmd_nack` pulses per valid command.
- **NOOP**, any state: ack; no state change.
- **START in IDLE:** ack.
  - `integration_clock_count` ← max(zero-extended `val << VAL_SHIFT`, MIN_COUNT).
  - Go to ARM and load the arm counter with ARM_CYCLES.
- **START in ARM, RUNNING or STOPPING:** nack, set `cmd_error`, no other change.
- **STOP in IDLE or STOPPING:** ack, no change.
- **STOP in ARM:** ack, abort to IDLE. `afe_reset` drops; `running` never asserts.
- **STOP in RUNNING:** ack, go to STOPPING. `running` stays high.
- **STOP with `frame_done` in the same cycle, in RUNNING:** ack, go straight to IDLE.
- **Reserved opcode:** nack, set `cmd_error`, no state change.
- **ARM:** the counter decrements each cycle; on reaching 0, go to RUNNING.
- **STOPPING:** `frame_done` moves the state to IDLE.
- `frame_done` outside RUNNING/STOPPING is ignored.
- `integration_clock_count` changes only on an accepted START, so it is stable for the whole run.
- Width rule: `val << VAL_SHIFT` is at most 65532 and is zero-extended to COUNT_WIDTH without truncation.

## Timing
- Every output is registered. Command at cycle t → ack/nack and state change visible at t+1.
- Accepted START at t:
  - `afe_reset` = 1 for cycles t+1 … t+ARM_CYCLES.
  - `running` = 1 from t+ARM_CYCLES+1.
  - `afe_reset` and `running` are never high together.
- STOP in RUNNING, `frame_done` arriving at t2: `running` = 0 from t2+1.
- **Reset values:**
  - state IDLE, `running` 0, `afe_reset` 0.
  - `integration_clock_count` DEFAULT_COUNT.
  - `cmd_ack`, `cmd_nack`, `cmd_error` all 0.
- Reset asserted mid-run: all outputs go to their reset values immediately and asynchronously.
- Reset release: registers update on the first clock edge after `reset_n` rises. A command presented on that edge is processed.

## Structure
- Shared package `afe_pkg` holds:
  - the opcode enum (NOOP/START/STOP/reserved)
  - the run-state enum
  - the opcode and value bit-field positions
- These are shared with the USB controller and readout controller.
- No sub-module: the arm counter and FSM are inline in one file.

## Test plan
1. Reset, then START with val=100 → at t+1: `cmd_ack`, `integration_clock_count`=400, `afe_reset`=1. `running`=1 at t+17.
2. START with val=5 → count clamped to 64. A second START while RUNNING → `cmd_nack`, `cmd_error`=1, count stays 64.
3. STOP while RUNNING, `frame_done` 30 cycles later → `running` stays 1 in STOPPING and drops 1 cycle after `frame_done`. `state_out` goes 2→3→0.
4. STOP on the same cycle as `frame_done` in RUNNING → IDLE and `running`=0 at t+1. STOP issued in ARM at cycle 5 of arming → IDLE, `running` never rises.
5. Opcode 11 in IDLE → `cmd_nack`, sticky `cmd_error`. A following NOOP → `cmd_ack`; `cmd_error` remains 1.
6. `reset_n` low while RUNNING, between clock edges → all outputs at reset values asynchronously, count=5000. After release, START with val=0 → count=64.
